id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage for the five-stage MIPS datapath. Sits directly downstream of the decode control unit and the register file. Each cycle it registers the decoded control bits, operands and register numbers for the EX stage. It also performs load-use hazard detection: it inserts bubbles, stalls the PC and IF/ID, honours branch flushes and downstream holds, and counts hazard stalls.

## Interface
- No parameters; datapath fixed at 32 bits, register numbers 5 bits.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- Valid_i  in  1  ID holds a real instruction.
- RegDst_i, ALUSrc_i, RegWrite_i, MemToReg_i, MemWrite_i, IsBranch_i  in  1 each  decode control bits.
- ALUOp_i  in  2  decode ALU operation class.
- RsData_i, RtData_i  in  32 each  register-file read data.
- Imm_i  in  16  instruction immediate.
- Rs_i, Rt_i, Rd_i  in  5 each  instruction register fields.
- Funct_i  in  6  instruction funct field.
- Flush_i  in  1  taken branch: kill the instruction currently in ID.
- Hold_i  in  1  EX cannot accept (multi-cycle op); freeze this stage.
- Stall_o  out  1  combinational; freeze PC and IF/ID this cycle.
- Valid_o, RegDst_o, ALUSrc_o, RegWrite_o, MemToReg_o, MemWrite_o, IsBranch_o  out  1 each  registered control.
- ALUOp_o  out  2  registered.
- RsData_o, RtData_o  out  32 each  registered operands.
- ImmExt_o  out  32  registered sign-extended Imm_i.
- Rs_o, Rt_o  out  5 each  registered source numbers, for forwarding.
- WriteReg_o  out  5  registered destination: RegDst_i ? Rd_i : Rt_i.
- Funct_o  out  6  registered.
- HazardCount_o  out  16  load-use stall cycles, saturating.

## Operation
- Reset (rst_i=1, asynchronous): all registered outputs 0, including HazardCount_o.
- UsesRt = RegDst_i | MemWrite_i | IsBranch_i.
- Hazard = Valid_i & Valid_o & MemToReg_o & (WriteReg_o != 0) & ((WriteReg_o == Rs_i) | (UsesRt & (WriteReg_o == Rt_i))).
- Stall_o = Hold_i | (Hazard & ~Flush_i).
- Per-edge action, first matching rule wins:
  - Hold_i=1: every register keeps its value. Counter unchanged.
  - Flush_i=1 or Valid_i=0: load bubble. Counter unchanged.
  - Hazard=1: load bubble. Counter +1, saturating at 16'hFFFF.
  - Otherwise: capture all inputs. Valid_o=1. ImmExt_o={{16{Imm_i[15]}},Imm_i}.
- Bubble means every registered output is 0 except HazardCount_o. A bubble therefore has RegWrite_o=0 and MemWrite_o=0.
- Control bits from decode are not pre-gated. This stage owns suppression via Valid_i and bubbles.
- A load-use pair costs exactly one stall cycle. After the bubble, Valid_o=0, so Hazard drops and the held ID instruction captures on the next edge.
- Hazard is never raised against destination $0.

## Timing
- Latency: 1 cycle, ID inputs to registered outputs.
- Stall_o is purely combinational from current inputs and registered outputs. It is valid in the same cycle as the hazard and must settle before the edge.
- Hold_i and a hazard in the same cycle: the hold wins. No bubble and no count that cycle. The hazard re-evaluates after the hold releases.
- Flush_i and a hazard in the same cycle: bubble, Stall_o=0 (unless Hold_i), counter unchanged.
- Reset asserted mid-stall: outputs clear immediately, without waiting for a clock. Stall_o then follows its equation with Valid_o=0, so it deasserts unless Hold_i=1.

## Test plan
- Reset: assert rst_i between edges -> all outputs 0 immediately; HazardCount_o=0; Stall_o=0 with Hold_i=0.
- Plain capture: add $3,$1,$2 with RsData_i=5, RtData_i=7, Rd_i=3, RegDst_i=1 -> next edge Valid_o=1, WriteReg_o=3, RsData_o=5, RtData_o=7.
- Sign extension: lw with Imm_i=16'h8004, RegDst_i=0, Rt_i=8 -> ImmExt_o=32'hFFFF8004, WriteReg_o=8, MemToReg_o=1.
- Load-use: lw $8 in EX, then add $9,$8,$1 in ID -> Stall_o=1 for one cycle, then a bubble (Valid_o=0, RegWrite_o=0), HazardCount_o=1, add captured on the following edge. Repeat with lw $0 -> no stall. Repeat with addi $9,$8 using rt=$8 only -> no stall, since UsesRt=0 for addi.
- Simultaneous events: hazard with Hold_i=1 -> outputs frozen, counter unchanged. Hazard with Flush_i=1 -> bubble, Stall_o=0, counter unchanged.
- Saturation: preload 65535 hazards -> HazardCount_o=16'hFFFF; one more hazard -> stays at 16'hFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage MIPS datapath, with load-use
// hazard detection, bubble insertion, hold/flush handling and a stall counter.
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Valid_i,
  input  logic        RegDst_i,
  input  logic        ALUSrc_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        MemWrite_i,
  input  logic        IsBranch_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [31:0] RsData_i,
  input  logic [31:0] RtData_i,
  input  logic [15:0] Imm_i,
  input  logic [4:0]  Rs_i,
  input  logic [4:0]  Rt_i,
  input  logic [4:0]  Rd_i,
  input  logic [5:0]  Funct_i,
  input  logic        Flush_i,
  input  logic        Hold_i,
  output logic        Stall_o,
  output logic        Valid_o,
  output logic        RegDst_o,
  output logic        ALUSrc_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic        MemWrite_o,
  output logic        IsBranch_o,
  output logic [1:0]  ALUOp_o,
  output logic [31:0] RsData_o,
  output logic [31:0] RtData_o,
  output logic [31:0] ImmExt_o,
  output logic [4:0]  Rs_o,
  output logic [4:0]  Rt_o,
  output logic [4:0]  WriteReg_o,
  output logic [5:0]  Funct_o,
  output logic [15:0] HazardCount_o
);

  typedef struct packed {
    logic        valid;
    logic        reg_dst;
    logic        alu_src;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        is_branch;
    logic [1:0]  alu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  write_reg;
    logic [5:0]  funct;
  } stage_t;

  stage_t      stage_q;
  stage_t      stage_d;
  logic [15:0] count_q;
  logic        uses_rt;
  logic        hazard;

  // A bubble is the all-zero stage, so RegWrite/MemWrite are suppressed too.
  always_comb begin
    stage_d            = '0;
    stage_d.valid      = 1'b1;
    stage_d.reg_dst    = RegDst_i;
    stage_d.alu_src    = ALUSrc_i;
    stage_d.reg_write  = RegWrite_i;
    stage_d.mem_to_reg = MemToReg_i;
    stage_d.mem_write  = MemWrite_i;
    stage_d.is_branch  = IsBranch_i;
    stage_d.alu_op     = ALUOp_i;
    stage_d.rs_data    = RsData_i;
    stage_d.rt_data    = RtData_i;
    stage_d.imm_ext    = {{16{Imm_i[15]}}, Imm_i};
    stage_d.rs         = Rs_i;
    stage_d.rt         = Rt_i;
    stage_d.write_reg  = RegDst_i ? Rd_i : Rt_i;
    stage_d.funct      = Funct_i;
  end

  always_comb begin
    uses_rt = RegDst_i | MemWrite_i | IsBranch_i;
    hazard  = Valid_i & stage_q.valid & stage_q.mem_to_reg &
              (stage_q.write_reg != '0) &
              ((stage_q.write_reg == Rs_i) | (uses_rt & (stage_q.write_reg == Rt_i)));
    Stall_o = Hold_i | (hazard & ~Flush_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
      count_q <= '0;
    end else if (!Hold_i) begin
      if (Flush_i || !Valid_i) begin
        stage_q <= '0;
      end else if (hazard) begin
        stage_q <= '0;
        if (count_q != '1) count_q <= count_q + 16'd1;
      end else begin
        stage_q <= stage_d;
      end
    end
  end

  assign Valid_o       = stage_q.valid;
  assign RegDst_o      = stage_q.reg_dst;
  assign ALUSrc_o      = stage_q.alu_src;
  assign RegWrite_o    = stage_q.reg_write;
  assign MemToReg_o    = stage_q.mem_to_reg;
  assign MemWrite_o    = stage_q.mem_write;
  assign IsBranch_o    = stage_q.is_branch;
  assign ALUOp_o       = stage_q.alu_op;
  assign RsData_o      = stage_q.rs_data;
  assign RtData_o      = stage_q.rt_data;
  assign ImmExt_o      = stage_q.imm_ext;
  assign Rs_o          = stage_q.rs;
  assign Rt_o          = stage_q.rt;
  assign WriteReg_o    = stage_q.write_reg;
  assign Funct_o       = stage_q.funct;
  assign HazardCount_o = count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, reset/saturation
// sequences, and randomized traffic against an instruction-level model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        Valid_i, RegDst_i, ALUSrc_i, RegWrite_i, MemToReg_i, MemWrite_i, IsBranch_i;
  logic [1:0]  ALUOp_i;
  logic [31:0] RsData_i, RtData_i;
  logic [15:0] Imm_i;
  logic [4:0]  Rs_i, Rt_i, Rd_i;
  logic [5:0]  Funct_i;
  logic        Flush_i, Hold_i;
  logic        Stall_o, Valid_o, RegDst_o, ALUSrc_o, RegWrite_o, MemToReg_o, MemWrite_o, IsBranch_o;
  logic [1:0]  ALUOp_o;
  logic [31:0] RsData_o, RtData_o, ImmExt_o;
  logic [4:0]  Rs_o, Rt_o, WriteReg_o;
  logic [5:0]  Funct_o;
  logic [15:0] HazardCount_o;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst), .Valid_i(Valid_i), .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i),
    .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i), .MemWrite_i(MemWrite_i),
    .IsBranch_i(IsBranch_i), .ALUOp_i(ALUOp_i), .RsData_i(RsData_i), .RtData_i(RtData_i),
    .Imm_i(Imm_i), .Rs_i(Rs_i), .Rt_i(Rt_i), .Rd_i(Rd_i), .Funct_i(Funct_i),
    .Flush_i(Flush_i), .Hold_i(Hold_i), .Stall_o(Stall_o), .Valid_o(Valid_o),
    .RegDst_o(RegDst_o), .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o),
    .MemToReg_o(MemToReg_o), .MemWrite_o(MemWrite_o), .IsBranch_o(IsBranch_o),
    .ALUOp_o(ALUOp_o), .RsData_o(RsData_o), .RtData_o(RtData_o), .ImmExt_o(ImmExt_o),
    .Rs_o(Rs_o), .Rt_o(Rt_o), .WriteReg_o(WriteReg_o), .Funct_o(Funct_o),
    .HazardCount_o(HazardCount_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, regdst, alusrc, regwrite, memtoreg, memwrite, isbranch;
    logic [1:0]  aluop;
    logic [31:0] rsd, rtd;
    logic [15:0] imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic        flush, hold;
  } in_t;

  typedef struct {
    string       name;
    in_t         in;
    logic        stall;
    logic        valid;
    logic [4:0]  wr;
    logic        regwrite, memtoreg;
    logic [31:0] rsd, rtd, imm;
    logic [15:0] cnt;
  } vec_t;

  // Model of the instruction sitting in EX, plus the stall tally.
  typedef struct {
    logic        valid, regdst, alusrc, regwrite, memtoreg, memwrite, isbranch;
    logic [1:0]  aluop;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rs, rt, wr;
    logic [5:0]  funct;
    int          count;
  } ex_t;

  int   checks = 0;
  int   failures = 0;
  ex_t  m;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic in_t f_nop(input logic [4:0] rs);
    in_t v = '{default: '0};
    v.rs = rs;
    return v;
  endfunction

  function automatic in_t f_add(input logic [4:0] rd, rs, rt, input logic [31:0] rsd, rtd);
    in_t v = '{default: '0};
    v.valid = 1; v.regdst = 1; v.regwrite = 1; v.aluop = 2'b10; v.funct = 6'h20;
    v.rd = rd; v.rs = rs; v.rt = rt; v.rsd = rsd; v.rtd = rtd;
    return v;
  endfunction

  function automatic in_t f_lw(input logic [4:0] rt, rs, input logic [15:0] imm, input logic [31:0] rsd);
    in_t v = '{default: '0};
    v.valid = 1; v.alusrc = 1; v.regwrite = 1; v.memtoreg = 1;
    v.rt = rt; v.rs = rs; v.imm = imm; v.rsd = rsd;
    return v;
  endfunction

  function automatic in_t f_addi(input logic [4:0] rt, rs, input logic [15:0] imm, input logic [31:0] rsd);
    in_t v = '{default: '0};
    v.valid = 1; v.alusrc = 1; v.regwrite = 1;
    v.rt = rt; v.rs = rs; v.imm = imm; v.rsd = rsd;
    return v;
  endfunction

  function automatic in_t f_sw(input logic [4:0] rt, rs, input logic [15:0] imm, input logic [31:0] rsd, rtd);
    in_t v = '{default: '0};
    v.valid = 1; v.alusrc = 1; v.memwrite = 1;
    v.rt = rt; v.rs = rs; v.imm = imm; v.rsd = rsd; v.rtd = rtd;
    return v;
  endfunction

  function automatic in_t with_ctl(input in_t v, input logic flush, hold);
    in_t r = v;
    r.flush = flush; r.hold = hold;
    return r;
  endfunction

  function automatic vec_t mkv(input string n, input in_t i, input logic st, v,
                               input logic [4:0] wr, input logic rw, mtr,
                               input logic [31:0] rsd, rtd, imm, input logic [15:0] c);
    vec_t r;
    r.name = n; r.in = i; r.stall = st; r.valid = v; r.wr = wr; r.regwrite = rw;
    r.memtoreg = mtr; r.rsd = rsd; r.rtd = rtd; r.imm = imm; r.cnt = c;
    return r;
  endfunction

  task automatic drive(input in_t v);
    Valid_i = v.valid; RegDst_i = v.regdst; ALUSrc_i = v.alusrc; RegWrite_i = v.regwrite;
    MemToReg_i = v.memtoreg; MemWrite_i = v.memwrite; IsBranch_i = v.isbranch;
    ALUOp_i = v.aluop; RsData_i = v.rsd; RtData_i = v.rtd; Imm_i = v.imm;
    Rs_i = v.rs; Rt_i = v.rt; Rd_i = v.rd; Funct_i = v.funct;
    Flush_i = v.flush; Hold_i = v.hold;
  endtask

  // Drive one ID instruction, check Stall_o before the edge, then advance.
  task automatic step(input in_t v, input logic exp_stall, input string name);
    drive(v);
    #2;
    chk({name, ".stall"}, {31'd0, Stall_o}, {31'd0, exp_stall});
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour: an instruction in EX that is a load to a nonzero
  // register blocks any valid ID instruction reading that register.
  task automatic model_step(input in_t v, output logic stall);
    logic load_pending, reads_rt, hazard;
    int   sv;
    load_pending = m.valid && m.memtoreg && (m.wr != 0);
    reads_rt     = v.regdst || v.memwrite || v.isbranch;
    hazard       = v.valid && load_pending &&
                   ((v.rs == m.wr) || (reads_rt && (v.rt == m.wr)));
    stall        = v.hold || (hazard && !v.flush);
    if (v.hold) begin
      // EX keeps its instruction
    end else if (v.flush || !v.valid || hazard) begin
      int c = m.count;
      if (!v.flush && hazard) c = (c < 65535) ? c + 1 : 65535;
      m = '{default: '0};
      m.count = c;
    end else begin
      sv = int'(v.imm);
      if (sv >= 32768) sv = sv - 65536;
      m.valid = 1; m.regdst = v.regdst; m.alusrc = v.alusrc; m.regwrite = v.regwrite;
      m.memtoreg = v.memtoreg; m.memwrite = v.memwrite; m.isbranch = v.isbranch;
      m.aluop = v.aluop; m.rsd = v.rsd; m.rtd = v.rtd; m.imm = 32'(sv);
      m.rs = v.rs; m.rt = v.rt; m.wr = v.regdst ? v.rd : v.rt; m.funct = v.funct;
    end
  endtask

  task automatic check_model(input string n);
    chk({n, ".valid"},    {31'd0, Valid_o},    {31'd0, m.valid});
    chk({n, ".regdst"},   {31'd0, RegDst_o},   {31'd0, m.regdst});
    chk({n, ".alusrc"},   {31'd0, ALUSrc_o},   {31'd0, m.alusrc});
    chk({n, ".regwrite"}, {31'd0, RegWrite_o}, {31'd0, m.regwrite});
    chk({n, ".memtoreg"}, {31'd0, MemToReg_o}, {31'd0, m.memtoreg});
    chk({n, ".memwrite"}, {31'd0, MemWrite_o}, {31'd0, m.memwrite});
    chk({n, ".isbranch"}, {31'd0, IsBranch_o}, {31'd0, m.isbranch});
    chk({n, ".aluop"},    {30'd0, ALUOp_o},    {30'd0, m.aluop});
    chk({n, ".rsdata"},   RsData_o,            m.rsd);
    chk({n, ".rtdata"},   RtData_o,            m.rtd);
    chk({n, ".immext"},   ImmExt_o,            m.imm);
    chk({n, ".rs"},       {27'd0, Rs_o},       {27'd0, m.rs});
    chk({n, ".rt"},       {27'd0, Rt_o},       {27'd0, m.rt});
    chk({n, ".writereg"}, {27'd0, WriteReg_o}, {27'd0, m.wr});
    chk({n, ".funct"},    {26'd0, Funct_o},    {26'd0, m.funct});
    chk({n, ".count"},    {16'd0, HazardCount_o}, 32'(m.count));
  endtask

  function automatic in_t rand_in();
    in_t v;
    v.valid    = ($urandom_range(99) < 85);
    v.regdst   = 1'($urandom);
    v.alusrc   = 1'($urandom);
    v.regwrite = 1'($urandom);
    v.memtoreg = ($urandom_range(99) < 40);
    v.memwrite = ($urandom_range(99) < 20);
    v.isbranch = ($urandom_range(99) < 15);
    v.aluop    = 2'($urandom);
    v.rsd      = $urandom;
    v.rtd      = $urandom;
    v.imm      = 16'($urandom);
    v.rs       = ($urandom_range(9) == 0) ? 5'($urandom) : 5'($urandom_range(3));
    v.rt       = ($urandom_range(9) == 0) ? 5'($urandom) : 5'($urandom_range(3));
    v.rd       = ($urandom_range(9) == 0) ? 5'($urandom) : 5'($urandom_range(3));
    v.funct    = 6'($urandom);
    v.flush    = ($urandom_range(99) < 10);
    v.hold     = ($urandom_range(99) < 10);
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_stall;
    in_t  add9;

    rst = 1'b1;
    drive(f_nop(5'd0));
    #2;
    chk("reset.valid",    {31'd0, Valid_o},       32'd0);
    chk("reset.regwrite", {31'd0, RegWrite_o},    32'd0);
    chk("reset.count",    {16'd0, HazardCount_o}, 32'd0);
    chk("reset.stall",    {31'd0, Stall_o},       32'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    add9 = f_add(5'd9, 5'd8, 5'd1, 32'd11, 32'd22);
    vecs.push_back(mkv("add3",       f_add(5'd3, 5'd1, 5'd2, 32'd5, 32'd7), 0, 1, 5'd3, 1, 0, 32'd5, 32'd7, 32'd0, 16'd0));
    vecs.push_back(mkv("lw8_sext",   f_lw(5'd8, 5'd1, 16'h8004, 32'd100), 0, 1, 5'd8, 1, 1, 32'd100, 32'd0, 32'hFFFF8004, 16'd0));
    vecs.push_back(mkv("ld_use",     add9, 1, 0, 5'd0, 0, 0, 32'd0, 32'd0, 32'd0, 16'd1));
    vecs.push_back(mkv("ld_use_cap", add9, 0, 1, 5'd9, 1, 0, 32'd11, 32'd22, 32'd0, 16'd1));
    vecs.push_back(mkv("lw0",        f_lw(5'd0, 5'd1, 16'h0004, 32'd100), 0, 1, 5'd0, 1, 1, 32'd100, 32'd0, 32'd4, 16'd1));
    vecs.push_back(mkv("use_r0",     f_add(5'd9, 5'd0, 5'd0, 32'd33, 32'd44), 0, 1, 5'd9, 1, 0, 32'd33, 32'd44, 32'd0, 16'd1));
    vecs.push_back(mkv("lw8_pos",    f_lw(5'd8, 5'd2, 16'h7FFC, 32'd200), 0, 1, 5'd8, 1, 1, 32'd200, 32'd0, 32'h00007FFC, 16'd1));
    vecs.push_back(mkv("addi_rt8",   f_addi(5'd8, 5'd1, 16'hFFFF, 32'd55), 0, 1, 5'd8, 1, 0, 32'd55, 32'd0, 32'hFFFFFFFF, 16'd1));
    vecs.push_back(mkv("lw8_c",      f_lw(5'd8, 5'd2, 16'h0010, 32'd200), 0, 1, 5'd8, 1, 1, 32'd200, 32'd0, 32'h10, 16'd1));
    vecs.push_back(mkv("haz_hold",   with_ctl(add9, 0, 1), 1, 1, 5'd8, 1, 1, 32'd200, 32'd0, 32'h10, 16'd1));
    vecs.push_back(mkv("haz_flush",  with_ctl(add9, 1, 0), 0, 0, 5'd0, 0, 0, 32'd0, 32'd0, 32'd0, 16'd1));
    vecs.push_back(mkv("lw8_d",      f_lw(5'd8, 5'd2, 16'h0010, 32'd200), 0, 1, 5'd8, 1, 1, 32'd200, 32'd0, 32'h10, 16'd1));
    vecs.push_back(mkv("sw_rt_haz",  f_sw(5'd8, 5'd2, 16'h0004, 32'd300, 32'd400), 1, 0, 5'd0, 0, 0, 32'd0, 32'd0, 32'd0, 16'd2));
    vecs.push_back(mkv("sw_cap",     f_sw(5'd8, 5'd2, 16'h0004, 32'd300, 32'd400), 0, 1, 5'd8, 0, 0, 32'd300, 32'd400, 32'd4, 16'd2));
    vecs.push_back(mkv("invalid",    f_nop(5'd8), 0, 0, 5'd0, 0, 0, 32'd0, 32'd0, 32'd0, 16'd2));
    vecs.push_back(mkv("lw8_e",      f_lw(5'd8, 5'd2, 16'h0010, 32'd200), 0, 1, 5'd8, 1, 1, 32'd200, 32'd0, 32'h10, 16'd2));
    vecs.push_back(mkv("invalid_rs8", f_nop(5'd8), 0, 0, 5'd0, 0, 0, 32'd0, 32'd0, 32'd0, 16'd2));
    vecs.push_back(mkv("hold_bubble", with_ctl(f_add(5'd3, 5'd1, 5'd2, 32'd5, 32'd7), 0, 1), 1, 0, 5'd0, 0, 0, 32'd0, 32'd0, 32'd0, 16'd2));
    vecs.push_back(mkv("add3_again", f_add(5'd3, 5'd1, 5'd2, 32'd5, 32'd7), 0, 1, 5'd3, 1, 0, 32'd5, 32'd7, 32'd0, 16'd2));

    foreach (vecs[i]) begin
      step(vecs[i].in, vecs[i].stall, vecs[i].name);
      chk({vecs[i].name, ".valid"},    {31'd0, Valid_o},    {31'd0, vecs[i].valid});
      chk({vecs[i].name, ".writereg"}, {27'd0, WriteReg_o}, {27'd0, vecs[i].wr});
      chk({vecs[i].name, ".regwrite"}, {31'd0, RegWrite_o}, {31'd0, vecs[i].regwrite});
      chk({vecs[i].name, ".memtoreg"}, {31'd0, MemToReg_o}, {31'd0, vecs[i].memtoreg});
      chk({vecs[i].name, ".rsdata"},   RsData_o,            vecs[i].rsd);
      chk({vecs[i].name, ".rtdata"},   RtData_o,            vecs[i].rtd);
      chk({vecs[i].name, ".immext"},   ImmExt_o,            vecs[i].imm);
      chk({vecs[i].name, ".count"},    {16'd0, HazardCount_o}, {16'd0, vecs[i].cnt});
    end

    // Reset arriving mid-stall clears everything without a clock edge.
    step(f_lw(5'd8, 5'd2, 16'h0010, 32'd200), 1'b0, "pre_rst_lw");
    drive(add9);
    #2;
    chk("mid_rst.stall_before", {31'd0, Stall_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst.valid",    {31'd0, Valid_o},       32'd0);
    chk("mid_rst.writereg", {27'd0, WriteReg_o},    32'd0);
    chk("mid_rst.memtoreg", {31'd0, MemToReg_o},    32'd0);
    chk("mid_rst.rsdata",   RsData_o,               32'd0);
    chk("mid_rst.count",    {16'd0, HazardCount_o}, 32'd0);
    chk("mid_rst.stall",    {31'd0, Stall_o},       32'd0);
    Hold_i = 1'b1;
    #1;
    chk("mid_rst.stall_hold", {31'd0, Stall_o}, 32'd1);
    Hold_i = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst.valid",    {31'd0, Valid_o},    32'd1);
    chk("post_rst.writereg", {27'd0, WriteReg_o}, 32'd9);

    #2 rst = 1'b1;
    #1 rst = 1'b0;
    m = '{default: '0};
    for (int n = 0; n < 2000; n++) begin
      in_t v;
      v = rand_in();
      model_step(v, exp_stall);
      step(v, exp_stall, "rand");
      check_model("rand");
    end

    // Counter preloaded near the top to reach saturation in a few cycles.
    drive(f_nop(5'd0));
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    step(f_lw(5'd8, 5'd2, 16'h0010, 32'd200), 1'b0, "sat_lw1");
    chk("sat.preload", {16'd0, HazardCount_o}, 32'h0000FFFE);
    step(add9, 1'b1, "sat_haz1");
    chk("sat.reach", {16'd0, HazardCount_o}, 32'h0000FFFF);
    step(f_lw(5'd8, 5'd2, 16'h0010, 32'd200), 1'b0, "sat_lw2");
    step(add9, 1'b1, "sat_haz2");
    chk("sat.hold", {16'd0, HazardCount_o}, 32'h0000FFFF);
    chk("sat.bubble_valid", {31'd0, Valid_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
